// File: rtl/pe.sv
// Unsigned MAC processing element: systolic stationary-weight path plus a serial N_TAPS dot-product path.
// Define PE_SAT_EN to make products and sums clamp at 2^DATA_W-1 instead of wrapping.
module pe #(
  parameter int DATA_W = 8,
  parameter int N_TAPS = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] y_in,
  input  logic              en_reg_A,
  input  logic              en_reg_B,
  input  logic              en_reg_Add,
  input  logic              en_reg_Acc,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] s_mode_out
);

  localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

  function automatic logic [DATA_W-1:0] f_mul(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    logic [2*DATA_W-1:0] full;
    full = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
`ifdef PE_SAT_EN
    return (|full[2*DATA_W-1:DATA_W]) ? {DATA_W{1'b1}} : full[DATA_W-1:0];
`else
    return full[DATA_W-1:0];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] f_add(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    logic [DATA_W:0] full;
    full = {1'b0, x} + {1'b0, y};
`ifdef PE_SAT_EN
    return full[DATA_W] ? {DATA_W{1'b1}} : full[DATA_W-1:0];
`else
    return full[DATA_W-1:0];
`endif
  endfunction

  logic [DATA_W-1:0] r_reg_A;
  logic [DATA_W-1:0] r_reg_B;
  logic [DATA_W-1:0] r_reg_Add;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_res;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_par_sum;
  logic [DATA_W-1:0] w_ser_sum;

  // Parallel product uses the weight held before the edge, even when reg_B loads in the same cycle.
  assign w_par_sum = f_add(y_in, f_mul(a_in, r_reg_B));
  assign w_ser_sum = f_add(r_acc, f_mul(a_in, b_in));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_A   <= '0;
      r_reg_B   <= '0;
      r_reg_Add <= '0;
    end else begin
      if (en_reg_A)   r_reg_A   <= a_in;
      if (en_reg_B)   r_reg_B   <= b_in;
      if (en_reg_Add) r_reg_Add <= w_par_sum;
    end
  end

  // The final tap writes the result and restarts the accumulator, so dot products run back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else if (en_reg_Acc) begin
      if (r_cnt == LAST_TAP) begin
        r_res <= w_ser_sum;
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_ser_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign a_out      = r_reg_A;
  assign y_out      = r_reg_Add;
  assign s_mode_out = r_res;

endmodule

// File: tb/tb_pe.sv
// Scoreboard bench for pe: expected results are queued as stimulus is driven and popped as outputs are produced.
module tb_pe;

  localparam int DATA_W = 8;
  localparam int N_TAPS = 9;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] y_in;
  logic              en_reg_A;
  logic              en_reg_B;
  logic              en_reg_Add;
  logic              en_reg_Acc;
  logic [DATA_W-1:0] y_out;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] s_mode_out;

  pe #(.DATA_W(DATA_W), .N_TAPS(N_TAPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_in       (a_in),
    .b_in       (b_in),
    .y_in       (y_in),
    .en_reg_A   (en_reg_A),
    .en_reg_B   (en_reg_B),
    .en_reg_Add (en_reg_Add),
    .en_reg_Acc (en_reg_Acc),
    .y_out      (y_out),
    .a_out      (a_out),
    .s_mode_out (s_mode_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int m_cnt  = 0;
  int m_last = 0;

  int c11_a[9] = '{1, 2, 3, 1, 2, 3, 1, 2, 3};
  int c12_a[9] = '{2, 3, 4, 2, 3, 4, 2, 3, 4};
  int cxx_b[9] = '{1, 1, 1, 2, 2, 2, 3, 3, 3};
  int ovf_v[9] = '{15, 15, 15, 15, 15, 15, 15, 15, 15};

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tap(input int a, input int b, input int exp_v);
    int got;
    a_in = a[DATA_W-1:0];
    b_in = b[DATA_W-1:0];
    en_reg_Acc = 1'b1;
    if (m_cnt == N_TAPS - 1) exp_q.push_back(exp_v);
    step();
    en_reg_Acc = 1'b0;
    if (m_cnt == N_TAPS - 1) begin
      m_cnt = 0;
      got = exp_q.pop_front();
      chk("serial_res", int'(s_mode_out), got);
      m_last = got;
    end else begin
      m_cnt++;
      chk("res_hold", int'(s_mode_out), m_last);
    end
  endtask

  task automatic run9(input int av[9], input int bv[9], input int exp_v);
    for (int i = 0; i < 9; i++) tap(av[i], bv[i], exp_v);
  endtask

  task automatic par_step(input logic ea, input logic eb, input logic ed,
                          input int a, input int b, input int y,
                          input int exp_a, input int exp_y);
    en_reg_A   = ea;
    en_reg_B   = eb;
    en_reg_Add = ed;
    a_in = a[DATA_W-1:0];
    b_in = b[DATA_W-1:0];
    y_in = y[DATA_W-1:0];
    exp_q.push_back(exp_a);
    exp_q.push_back(exp_y);
    step();
    chk("a_out", int'(a_out), exp_q.pop_front());
    chk("y_out", int'(y_out), exp_q.pop_front());
  endtask

  initial begin
    // Reset with every enable high and unit operands: nothing may load or accumulate.
    rst = 1'b1;
    a_in = 8'd1; b_in = 8'd1; y_in = 8'd1;
    en_reg_A = 1'b1; en_reg_B = 1'b1; en_reg_Add = 1'b1; en_reg_Acc = 1'b1;
    #2;
    repeat (3) begin
      step();
      chk("rst_a_out", int'(a_out), 0);
      chk("rst_y_out", int'(y_out), 0);
      chk("rst_s_out", int'(s_mode_out), 0);
    end
    rst = 1'b0;
    en_reg_A = 1'b0; en_reg_B = 1'b0; en_reg_Add = 1'b0; en_reg_Acc = 1'b0;
    step();

    // c11 then back-to-back c12, c21, c22.
    run9(c11_a, cxx_b, 36);
    run9(c12_a, cxx_b, 54);
    run9(c11_a, cxx_b, 36);
    run9(c12_a, cxx_b, 54);

    // Parallel path.
    par_step(1'b0, 1'b1, 1'b0, 0, 3, 0, 0, 0);
    par_step(1'b1, 1'b0, 1'b1, 2, 3, 5, 2, 11);
    par_step(1'b1, 1'b0, 1'b1, 2, 3, 5, 2, 11);
    par_step(1'b0, 1'b0, 1'b0, 7, 1, 9, 2, 11);
    par_step(1'b0, 1'b0, 1'b0, 7, 1, 9, 2, 11);
    // Weight load and partial-sum load on the same edge: product sees the old weight (3).
    par_step(1'b0, 1'b1, 1'b1, 2, 5, 1, 2, 7);
    par_step(1'b0, 1'b0, 1'b1, 2, 9, 1, 2, 11);
    en_reg_Add = 1'b0;

    // Pause mid-accumulation; the result must match an uninterrupted c11.
    for (int i = 0; i < 4; i++) tap(c11_a[i], cxx_b[i], 36);
    a_in = 8'd9; b_in = 8'd9;
    repeat (3) begin
      step();
      chk("pause_hold", int'(s_mode_out), m_last);
    end
    for (int i = 4; i < 9; i++) tap(c11_a[i], cxx_b[i], 36);

    // Asynchronous reset pulse between edges after 4 taps discards the partial sum.
    for (int i = 0; i < 4; i++) tap(15, 15, 0);
    #2 rst = 1'b1;
    #1 chk("async_rst_s_out", int'(s_mode_out), 0);
    chk("async_rst_a_out", int'(a_out), 0);
    chk("async_rst_y_out", int'(y_out), 0);
    #1 rst = 1'b0;
    m_cnt = 0;
    m_last = 0;
    step();
    run9(c11_a, cxx_b, 36);

    // Overflow: 9 x 225.
`ifdef PE_SAT_EN
    run9(ovf_v, ovf_v, 255);
`else
    run9(ovf_v, ovf_v, 233);
`endif
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
